// File: rtl/index_extractor_rr.sv
// index_extractor_rr: round-robin AR/AW request front end that packs accepted requests into the request FIFO
module index_extractor_rr #(
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = 8,
    parameter int INDEX_BIT_SIZE = 4,
    parameter int OFFSET_BITS    = 6,
    parameter int CNT_WIDTH      = 16,
    localparam int ENTRY_WIDTH   = 1 + ID_WIDTH + ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ID_WIDTH-1:0]       arid_i,
    input  logic [ADDR_WIDTH-1:0]     araddr_i,
    input  logic                      arvalid_i,
    output logic                      arready_o,
    input  logic [ID_WIDTH-1:0]       awid_i,
    input  logic [ADDR_WIDTH-1:0]     awaddr_i,
    input  logic                      awvalid_i,
    output logic                      awready_o,
    input  logic                      fifo_afull_i,
    output logic                      fifo_wr_en_o,
    output logic [ENTRY_WIDTH-1:0]    fifo_data_o,
    output logic [INDEX_BIT_SIZE-1:0] index_o,
    output logic [CNT_WIDTH-1:0]      rd_cnt_o,
    output logic [CNT_WIDTH-1:0]      wr_cnt_o
);
    logic                      last_aw;
    logic                      wr_en_q;
    logic [ENTRY_WIDTH-1:0]    data_q;
    logic [INDEX_BIT_SIZE-1:0] idx_q;
    logic                      open;

    // Contention goes to the channel that did not win last; a lone valid is granted directly.
    assign open      = !rst && !fifo_afull_i;
    assign arready_o = open && arvalid_i && (!awvalid_i || last_aw);
    assign awready_o = open && awvalid_i && (!arvalid_i || !last_aw);

    // A push registered just before reset is suppressed while rst is high.
    assign fifo_wr_en_o = wr_en_q && !rst;
    assign fifo_data_o  = rst ? '0 : data_q;
    assign index_o      = rst ? '0 : idx_q;

    // Capture the granted request for a push on the following cycle and remember the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_aw <= 1'b1;
            wr_en_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            wr_en_q <= arready_o || awready_o;
            data_q  <= awready_o ? {awaddr_i, awid_i, 1'b1} :
                       arready_o ? {araddr_i, arid_i, 1'b0} : '0;
            idx_q   <= awready_o ? awaddr_i[OFFSET_BITS +: INDEX_BIT_SIZE] :
                       arready_o ? araddr_i[OFFSET_BITS +: INDEX_BIT_SIZE] : '0;
            if (arready_o || awready_o)
                last_aw <= awready_o;
        end
    end

    // Per-channel acceptance counters that stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else begin
            if (arready_o && rd_cnt_o != '1)
                rd_cnt_o <= rd_cnt_o + 1'b1;
            if (awready_o && wr_cnt_o != '1)
                wr_cnt_o <= wr_cnt_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_index_extractor_rr.sv
// tb_index_extractor_rr: scoreboard bench for the round-robin request front end
module tb_index_extractor_rr;
    localparam int AW  = 32;
    localparam int IW  = 8;
    localparam int IB  = 4;
    localparam int OFF = 6;
    localparam int CW  = 2;
    localparam int EW  = 1 + IW + AW;

    typedef struct packed {
        logic [EW-1:0] d;
        logic [IB-1:0] i;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [IW-1:0] arid_i = '0, awid_i = '0;
    logic [AW-1:0] araddr_i = '0, awaddr_i = '0;
    logic          arvalid_i = 1'b0, awvalid_i = 1'b0, fifo_afull_i = 1'b0;
    logic          arready_o, awready_o, fifo_wr_en_o;
    logic [EW-1:0] fifo_data_o;
    logic [IB-1:0] index_o;
    logic [CW-1:0] rd_cnt_o, wr_cnt_o;

    int   n_chk = 0, n_pass = 0;
    bit   en = 1'b0;
    ent_t q[$];
    logic exp_ar = 1'b0, exp_aw = 1'b0, m_last_aw = 1'b1;
    logic [CW-1:0] m_rd = '0, m_wr = '0;

    index_extractor_rr #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .INDEX_BIT_SIZE(IB),
                         .OFFSET_BITS(OFF), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .arid_i(arid_i), .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .fifo_afull_i(fifo_afull_i), .fifo_wr_en_o(fifo_wr_en_o), .fifo_data_o(fifo_data_o),
        .index_o(index_o), .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, predict grants, and queue the push expected after the edge.
    task automatic tick(input logic arv, input logic [AW-1:0] ara, input logic [IW-1:0] ari,
                        input logic awv, input logic [AW-1:0] awa, input logic [IW-1:0] awi,
                        input logic af, input logic r);
        arvalid_i = arv; araddr_i = ara; arid_i = ari;
        awvalid_i = awv; awaddr_i = awa; awid_i = awi;
        fifo_afull_i = af; rst = r;
        exp_ar = !r && !af && arv && (!awv || m_last_aw);
        exp_aw = !r && !af && awv && (!arv || !m_last_aw);
        if (r) q.delete();
        @(posedge clk);
        if (r) begin
            m_last_aw = 1'b1; m_rd = '0; m_wr = '0;
        end else if (exp_ar) begin
            q.push_back('{d: {ara, ari, 1'b0}, i: ara[OFF +: IB]});
            m_last_aw = 1'b0;
            if (m_rd != '1) m_rd = m_rd + 1'b1;
        end else if (exp_aw) begin
            q.push_back('{d: {awa, awi, 1'b1}, i: awa[OFF +: IB]});
            m_last_aw = 1'b1;
            if (m_wr != '1) m_wr = m_wr + 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        tick(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Scoreboard: every cycle compare readies, the popped push and the counters.
    always @(negedge clk) begin
        if (en) begin
            ent_t e;
            n_chk++;
            if ({arready_o, awready_o} !== {exp_ar, exp_aw})
                $display("FAIL sb_ready got ar=%b aw=%b exp ar=%b aw=%b", arready_o, awready_o, exp_ar, exp_aw);
            else n_pass++;
            e = '0;
            n_chk++;
            if (fifo_wr_en_o !== (q.size() != 0))
                $display("FAIL sb_wr_en got %b exp %b", fifo_wr_en_o, q.size() != 0);
            else n_pass++;
            if (q.size() != 0) e = q.pop_front();
            n_chk++;
            if ({fifo_data_o, index_o} !== e)
                $display("FAIL sb_entry got data=%h idx=%h exp data=%h idx=%h", fifo_data_o, index_o, e.d, e.i);
            else n_pass++;
            n_chk++;
            if ({rd_cnt_o, wr_cnt_o} !== {m_rd, m_wr})
                $display("FAIL sb_cnt got rd=%0d wr=%0d exp rd=%0d wr=%0d", rd_cnt_o, wr_cnt_o, m_rd, m_wr);
            else n_pass++;
        end
    end

    task automatic do_reset();
        tick(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        en = 1'b1;
        tick(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        idle();
        n_chk++;
        if ({arready_o, awready_o, fifo_wr_en_o, fifo_data_o, index_o, rd_cnt_o, wr_cnt_o} !== '0)
            $display("FAIL reset_outputs got wr=%b data=%h idx=%h rd=%0d wr=%0d", fifo_wr_en_o, fifo_data_o, index_o, rd_cnt_o, wr_cnt_o);
        else n_pass++;
    endtask

    task automatic test_single_read();
        tick(1'b1, 32'h0000_1240, 8'h05, 1'b0, '0, '0, 1'b0, 1'b0);
        n_chk++;
        if ({fifo_wr_en_o, index_o} !== {1'b1, 4'h9})
            $display("FAIL single_idx got wr=%b idx=%h exp wr=1 idx=9", fifo_wr_en_o, index_o);
        else n_pass++;
        n_chk++;
        if (fifo_data_o !== {32'h0000_1240, 8'h05, 1'b0})
            $display("FAIL single_data got %h exp %h", fifo_data_o, {32'h0000_1240, 8'h05, 1'b0});
        else n_pass++;
        n_chk++;
        if (rd_cnt_o !== 2'd1) $display("FAIL single_cnt got %0d exp 1", rd_cnt_o);
        else n_pass++;
        idle();
    endtask

    task automatic test_alternate();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 32'h100 + k * 64, 8'(k), 1'b1, 32'h2000 + k * 64, 8'(k + 8), 1'b0, 1'b0);
            n_chk++;
            if ({fifo_wr_en_o, fifo_data_o[0]} !== {1'b1, 1'(k % 2)})
                $display("FAIL alt_rw[%0d] got wr=%b rw=%b exp wr=1 rw=%0d", k, fifo_wr_en_o, fifo_data_o[0], k % 2);
            else n_pass++;
        end
        n_chk++;
        if ({rd_cnt_o, wr_cnt_o} !== {2'd2, 2'd2})
            $display("FAIL alt_cnt got rd=%0d wr=%0d exp 2 2", rd_cnt_o, wr_cnt_o);
        else n_pass++;
    endtask

    task automatic test_aw_stream();
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, '0, '0, 1'b1, 32'h4000 + k * 64, 8'(k), 1'b0, 1'b0);
            n_chk++;
            if ({fifo_wr_en_o, fifo_data_o[0]} !== 2'b11)
                $display("FAIL aw_stream[%0d] got wr=%b rw=%b exp wr=1 rw=1", k, fifo_wr_en_o, fifo_data_o[0]);
            else n_pass++;
        end
        tick(1'b1, 32'h5040, 8'h33, 1'b1, 32'h6080, 8'h44, 1'b0, 1'b0);
        n_chk++;
        if ({fifo_wr_en_o, fifo_data_o[0]} !== 2'b10)
            $display("FAIL aw_then_ar got wr=%b rw=%b exp wr=1 rw=0", fifo_wr_en_o, fifo_data_o[0]);
        else n_pass++;
    endtask

    task automatic test_afull();
        tick(1'b1, 32'h7000, 8'h01, 1'b1, 32'h7040, 8'h02, 1'b0, 1'b0);
        n_chk++;
        if (fifo_data_o[0] !== 1'b1) $display("FAIL afull_pre got rw=%b exp 1", fifo_data_o[0]);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 32'h7000, 8'h01, 1'b1, 32'h7040, 8'h02, 1'b1, 1'b0);
            n_chk++;
            if ({fifo_wr_en_o, arready_o, awready_o} !== 3'b000)
                $display("FAIL afull_block[%0d] got wr=%b ar=%b aw=%b exp 0 0 0", k, fifo_wr_en_o, arready_o, awready_o);
            else n_pass++;
        end
        tick(1'b1, 32'h7000, 8'h01, 1'b1, 32'h7040, 8'h02, 1'b0, 1'b0);
        n_chk++;
        if ({fifo_wr_en_o, fifo_data_o[0]} !== 2'b10)
            $display("FAIL afull_resume got wr=%b rw=%b exp wr=1 rw=0", fifo_wr_en_o, fifo_data_o[0]);
        else n_pass++;
        idle();
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 32'h8000, 8'h07, 1'b0, '0, '0, 1'b0, 1'b0);
        tick(1'b1, 32'h8000, 8'h07, 1'b1, 32'h8040, 8'h08, 1'b0, 1'b1);
        n_chk++;
        if ({arready_o, awready_o, fifo_wr_en_o, fifo_data_o, index_o, rd_cnt_o, wr_cnt_o} !== '0)
            $display("FAIL rst_mid_outputs got wr=%b data=%h rd=%0d wr=%0d", fifo_wr_en_o, fifo_data_o, rd_cnt_o, wr_cnt_o);
        else n_pass++;
        tick(1'b1, 32'h8080, 8'h09, 1'b1, 32'h80c0, 8'h0a, 1'b0, 1'b0);
        n_chk++;
        if ({fifo_wr_en_o, fifo_data_o[0]} !== 2'b10)
            $display("FAIL rst_mid_first got wr=%b rw=%b exp wr=1 rw=0", fifo_wr_en_o, fifo_data_o[0]);
        else n_pass++;
        idle();
    endtask

    task automatic test_saturate();
        logic [CW-1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 32'h9000 + k * 64, 8'(k), 1'b0, '0, '0, 1'b0, 1'b0);
            n_chk++;
            if ({fifo_wr_en_o, rd_cnt_o} !== {1'b1, exp_cnt[k]})
                $display("FAIL sat[%0d] got wr=%b cnt=%0d exp wr=1 cnt=%0d", k, fifo_wr_en_o, rd_cnt_o, exp_cnt[k]);
            else n_pass++;
        end
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 60; k++)
            tick(1'($urandom_range(0, 1)), $urandom, 8'($urandom), 1'($urandom_range(0, 1)), $urandom,
                 8'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
        idle();
        idle();
        n_chk++;
        if (q.size() !== 0) $display("FAIL b2b_drain got %0d pending exp 0", q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_alternate();
        test_aw_stream();
        test_afull();
        test_reset_mid();
        test_saturate();
        test_back_to_back();
        en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
